// File: rtl/usb_dbg_ctrl_ep_if.sv
// Endpoint-side streams of the debug control endpoint: setup packets, data
// stages in both directions and the per-request status pulse.
interface usb_dbg_ctrl_ep_if #(
  parameter int DW = 64
) ();
  logic          setup_valid;
  logic [63:0]   setup_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          status_valid;
  logic          status_stall;
  logic          busy;

  modport master (
    output setup_valid, setup_data, out_valid, out_data, in_ready,
    input  out_ready, in_valid, in_data, status_valid, status_stall, busy
  );

  modport slave (
    input  setup_valid, setup_data, out_valid, out_data, in_ready,
    output out_ready, in_valid, in_data, status_valid, status_stall, busy
  );
endinterface

// File: rtl/usb_dbg_ctrl_ep.sv
// Debug-class control endpoint: decodes class SET/GET setup packets, moves
// data-stage words to/from the per-unit config store and reports ACK/STALL.
module usb_dbg_ctrl_ep #(
  parameter int          DW        = 64,
  parameter int          NUM_UNITS = 4,
  parameter int          CFG_WORDS = 8,
  parameter logic [31:0] CAPS      = 32'h0000_380F
) (
  input  logic                              clk,
  input  logic                              rst,
  usb_dbg_ctrl_ep_if.slave                  ep,
  output logic [NUM_UNITS*CFG_WORDS*DW-1:0] cfg_flat,
  output logic [8*NUM_UNITS-1:0]            op_mode,
  output logic [7:0]                        err_code
);
  localparam int BPW   = DW / 8;
  localparam int LBPW  = $clog2(BPW);
  localparam int DEPTH = NUM_UNITS * CFG_WORDS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DECODE   = 3'd1;
  localparam logic [2:0] OUT_DATA = 3'd2;
  localparam logic [2:0] IN_DATA  = 3'd3;
  localparam logic [2:0] STATUS   = 3'd4;
  localparam logic [2:0] STALL    = 3'd5;

  localparam logic [7:0] ERR_NONE  = 8'h00;
  localparam logic [7:0] ERR_RANGE = 8'h06;
  localparam logic [7:0] ERR_UNIT  = 8'h07;
  localparam logic [7:0] ERR_REQ   = 8'h09;

  logic [2:0]    state_reg;
  logic [7:0]    rtype_reg;
  logic [7:0]    breq_reg;
  logic [7:0]    wvalue_reg;
  logic [7:0]    unit_reg;
  logic [15:0]   wlen_reg;
  logic [7:0]    idx_reg;
  logic [15:0]   left_reg;
  logic [DW-1:0] in_data_reg;
  logic [7:0]    err_reg;

  logic [UW-1:0] unit_idx;
  logic          unit_ok;
  logic          multi_ok;
  logic          single_ok;
  logic          dec_known;
  logic          dec_get;
  logic          dec_range_ok;
  logic          dec_has_data;
  logic [7:0]    dec_start;
  logic [15:0]   dec_words;
  logic [7:0]    dec_err;
  logic          is_get_error;
  logic          wr_en;
  logic          act_en;
  logic          mode_en;
  logic          clr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    rd_word;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_value;
  logic          unused_bits;

  // wValue high byte and wIndex low byte carry nothing for this class.
  assign unused_bits = ^{ep.setup_data[47:40], ep.setup_data[23:16]};

  assign unit_idx  = unit_reg[UW-1:0];
  assign unit_ok   = 32'(unit_reg) < NUM_UNITS;
  assign multi_ok  = (wlen_reg != '0) && (wlen_reg[LBPW-1:0] == '0) &&
                     (32'(wlen_reg) <= CFG_WORDS * BPW);
  assign single_ok = (32'(wvalue_reg) < CFG_WORDS) && (32'(wlen_reg) == BPW);
  assign is_get_error = ({rtype_reg, breq_reg} == 16'hA188);

  always_comb begin
    dec_known    = 1'b0;
    dec_get      = 1'b0;
    dec_range_ok = 1'b0;
    dec_has_data = 1'b0;
    dec_start    = '0;
    dec_words    = 16'd1;
    case ({rtype_reg, breq_reg})
      16'h2101, 16'hA181: begin
        dec_known    = 1'b1;
        dec_get      = rtype_reg[7];
        dec_range_ok = multi_ok;
        dec_has_data = 1'b1;
        dec_words    = wlen_reg >> LBPW;
      end
      16'h2102, 16'hA182: begin
        dec_known    = 1'b1;
        dec_get      = rtype_reg[7];
        dec_range_ok = single_ok;
        dec_has_data = 1'b1;
        dec_start    = wvalue_reg;
      end
      16'h2105, 16'h210A: begin
        dec_known    = 1'b1;
        dec_range_ok = (wlen_reg == '0);
      end
      16'hA185, 16'hA187, 16'hA188: begin
        dec_known    = 1'b1;
        dec_get      = 1'b1;
        dec_range_ok = 1'b1;
        dec_has_data = (wlen_reg != '0);
      end
      default: ;
    endcase
    if (!dec_known)         dec_err = ERR_REQ;
    else if (!unit_ok)      dec_err = ERR_UNIT;
    else if (!dec_range_ok) dec_err = ERR_RANGE;
    else                    dec_err = ERR_NONE;
  end

  // A new setup packet pre-empts both data-stage writes and decode actions.
  assign wr_en   = (state_reg == OUT_DATA) && ep.out_valid && !ep.setup_valid;
  assign act_en  = (state_reg == DECODE) && !ep.setup_valid && (dec_err == ERR_NONE);
  assign mode_en = act_en && ({rtype_reg, breq_reg} == 16'h2105);
  assign clr_en  = act_en && ({rtype_reg, breq_reg} == 16'h210A);
  assign wr_addr = AW'(32'(unit_idx) * CFG_WORDS + 32'(idx_reg));

  assign rd_word = (state_reg == DECODE) ? dec_start : idx_reg + 8'd1;
  assign rd_addr = AW'(32'(unit_idx) * CFG_WORDS + 32'(rd_word));

  always_comb begin
    case (breq_reg)
      8'h85:   rd_value = DW'(op_mode[32'(unit_idx)*8 +: 8]);
      8'h87:   rd_value = DW'(CAPS);
      8'h88:   rd_value = DW'(err_reg);
      default: rd_value = cfg_flat[32'(rd_addr)*DW +: DW];
    endcase
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DW-1:0] word_reg;
    always_ff @(posedge clk) begin
      if (rst)
        word_reg <= '0;
      else if (clr_en && unit_idx == UW'(gi / CFG_WORDS))
        word_reg <= '0;
      else if (wr_en && wr_addr == AW'(gi))
        word_reg <= ep.out_data;
    end
    assign cfg_flat[gi*DW +: DW] = word_reg;
  end

  for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    logic [7:0] mode_reg;
    always_ff @(posedge clk) begin
      if (rst)
        mode_reg <= '0;
      else if (clr_en && unit_idx == UW'(gi))
        mode_reg <= '0;
      else if (mode_en && unit_idx == UW'(gi))
        mode_reg <= wvalue_reg;
    end
    assign op_mode[gi*8 +: 8] = mode_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rtype_reg   <= '0;
      breq_reg    <= '0;
      wvalue_reg  <= '0;
      unit_reg    <= '0;
      wlen_reg    <= '0;
      idx_reg     <= '0;
      left_reg    <= '0;
      in_data_reg <= '0;
      err_reg     <= ERR_NONE;
    end else if (ep.setup_valid) begin
      rtype_reg  <= ep.setup_data[63:56];
      breq_reg   <= ep.setup_data[55:48];
      wvalue_reg <= ep.setup_data[39:32];
      unit_reg   <= ep.setup_data[31:24];
      wlen_reg   <= ep.setup_data[15:0];
      state_reg  <= DECODE;
      if (state_reg == STATUS && !is_get_error)
        err_reg <= ERR_NONE;
    end else begin
      case (state_reg)
        DECODE: begin
          if (dec_err != ERR_NONE) begin
            err_reg   <= dec_err;
            state_reg <= STALL;
          end else if (dec_has_data) begin
            idx_reg  <= dec_start;
            left_reg <= dec_words;
            if (dec_get) begin
              in_data_reg <= rd_value;
              state_reg   <= IN_DATA;
            end else begin
              state_reg <= OUT_DATA;
            end
          end else begin
            state_reg <= STATUS;
          end
        end
        OUT_DATA: begin
          if (ep.out_valid) begin
            idx_reg  <= idx_reg + 8'd1;
            left_reg <= left_reg - 16'd1;
            if (left_reg == 16'd1)
              state_reg <= STATUS;
          end
        end
        IN_DATA: begin
          if (ep.in_ready) begin
            if (left_reg == 16'd1) begin
              state_reg <= STATUS;
            end else begin
              idx_reg     <= idx_reg + 8'd1;
              left_reg    <= left_reg - 16'd1;
              in_data_reg <= rd_value;
            end
          end
        end
        STATUS: begin
          if (!is_get_error)
            err_reg <= ERR_NONE;
          state_reg <= IDLE;
        end
        STALL:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ep.out_ready    = (state_reg == OUT_DATA);
  assign ep.in_valid     = (state_reg == IN_DATA);
  assign ep.in_data      = in_data_reg;
  assign ep.status_valid = (state_reg == STATUS) || (state_reg == STALL);
  assign ep.status_stall = (state_reg == STALL);
  assign ep.busy         = (state_reg != IDLE);
  assign err_code        = err_reg;
endmodule

// File: tb/tb_usb_dbg_ctrl_ep.sv
// Directed bench for usb_dbg_ctrl_ep with a request-level model of the store,
// modes and error code, checked every cycle, plus per-request handshake checks.
module tb_usb_dbg_ctrl_ep;
  localparam int          DW   = 64;
  localparam int          NU   = 4;
  localparam int          CW   = 8;
  localparam logic [31:0] CAPS = 32'h0000_380F;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NU*CW*DW-1:0]   cfg_flat;
  logic [8*NU-1:0]       op_mode;
  logic [7:0]            err_code;

  usb_dbg_ctrl_ep_if #(.DW(DW)) bus ();

  usb_dbg_ctrl_ep #(.DW(DW), .NUM_UNITS(NU), .CFG_WORDS(CW), .CAPS(CAPS)) dut (
    .clk      (clk),
    .rst      (rst),
    .ep       (bus),
    .cfg_flat (cfg_flat),
    .op_mode  (op_mode),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [63:0] m_cfg [NU][CW];
  logic [7:0]  m_mode [NU];
  logic [7:0]  m_err;
  logic [63:0] wbuf [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      m_mode[u] = 8'h00;
      for (int w = 0; w < CW; w++) m_cfg[u][w] = 64'h0;
    end
    m_err = 8'h00;
  endtask

  // Error code a request must produce, straight from the decode rules.
  function automatic logic [7:0] model_code(input logic [63:0] s);
    logic [7:0]  rt, br;
    logic [15:0] wl;
    int          unit, wv;
    bit          known, ok;
    rt = s[63:56]; br = s[55:48]; wv = int'(s[39:32]); unit = int'(s[31:24]); wl = s[15:0];
    known = (rt == 8'h21 && br inside {8'h01, 8'h02, 8'h05, 8'h0A}) ||
            (rt == 8'hA1 && br inside {8'h81, 8'h82, 8'h85, 8'h87, 8'h88});
    if (!known) return 8'h09;
    if (unit >= NU) return 8'h07;
    case (br)
      8'h01, 8'h81: ok = (wl != 0) && (wl % 8 == 0) && (int'(wl) <= CW * 8);
      8'h02, 8'h82: ok = (wv < CW) && (wl == 16'd8);
      8'h05, 8'h0A: ok = (wl == 16'd0);
      default:      ok = 1'b1;
    endcase
    return ok ? 8'h00 : 8'h06;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < NU; u++) begin
        for (int w = 0; w < CW; w++)
          check($sformatf("cfg_u%0d_w%0d", u, w), cfg_flat[(u*CW+w)*DW +: DW], m_cfg[u][w]);
        check($sformatf("op_mode_u%0d", u), op_mode[u*8 +: 8], m_mode[u]);
      end
      check("err_code", err_code, m_err);
    end
  end

  task automatic issue_setup(input logic [63:0] s);
    bus.setup_valid = 1'b1;
    bus.setup_data  = s;
    @(posedge clk); #1;
    bus.setup_valid = 1'b0;
  endtask

  // Called in the DECODE cycle; runs the request to its status pulse.
  task automatic finish_request(input logic [63:0] s, input int bp);
    logic [7:0]  rt, br, wv, code;
    logic [15:0] wl;
    logic [63:0] exp;
    int          unit, n, start;
    rt = s[63:56]; br = s[55:48]; wv = s[39:32]; unit = int'(s[31:24]); wl = s[15:0];
    check("decode_busy", bus.busy, 1);
    check("decode_quiet", {bus.status_valid, bus.out_ready, bus.in_valid}, 0);
    @(posedge clk); #1;
    code = model_code(s);
    $display("req %h -> code %h", s, code);
    if (code != 8'h00) begin
      m_err = code;
      check("stall_pulse", {bus.status_valid, bus.status_stall}, 2'b11);
      @(posedge clk); #1;
      check("stall_done", {bus.status_valid, bus.busy}, 0);
      return;
    end
    start = (br == 8'h02 || br == 8'h82) ? int'(wv) : 0;
    case (br)
      8'h01, 8'h81:        n = int'(wl) / 8;
      8'h02, 8'h82:        n = 1;
      8'h85, 8'h87, 8'h88: n = (wl != 0) ? 1 : 0;
      default:             n = 0;
    endcase
    if (n == 0) begin
      if (br == 8'h05) m_mode[unit] = wv;
      if (br == 8'h0A) begin
        m_mode[unit] = 8'h00;
        for (int w = 0; w < CW; w++) m_cfg[unit][w] = 64'h0;
      end
    end else if (rt == 8'h21) begin
      for (int i = 0; i < n; i++) begin
        check("out_ready", bus.out_ready, 1);
        check("no_status_mid", bus.status_valid, 0);
        bus.out_valid = 1'b1;
        bus.out_data  = wbuf[i];
        @(posedge clk); #1;
        bus.out_valid = 1'b0;
        m_cfg[unit][start+i] = wbuf[i];
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        case (br)
          8'h85:   exp = 64'(m_mode[unit]);
          8'h87:   exp = 64'(CAPS);
          8'h88:   exp = 64'(m_err);
          default: exp = m_cfg[unit][start+i];
        endcase
        for (int k = 0; k < bp && i == 0; k++) begin
          check("in_valid_hold", bus.in_valid, 1);
          check("in_data_hold", bus.in_data, exp);
          @(posedge clk); #1;
        end
        check("in_valid", bus.in_valid, 1);
        check($sformatf("in_data_%0d", i), bus.in_data, exp);
        bus.in_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_ready = 1'b0;
      end
    end
    check("ack_pulse", {bus.status_valid, bus.status_stall}, 2'b10);
    @(posedge clk); #1;
    if (!(rt == 8'hA1 && br == 8'h88)) m_err = 8'h00;
    check("ack_done", {bus.status_valid, bus.busy}, 0);
  endtask

  task automatic request(input logic [63:0] s, input int bp);
    issue_setup(s);
    finish_request(s, bp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.setup_valid = 1'b1;
    bus.setup_data  = 64'h2105_0003_0000_0000;
    bus.out_valid   = 1'b0;
    bus.out_data    = '0;
    bus.in_ready    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_handshake", {bus.out_ready, bus.in_valid, bus.status_valid, bus.status_stall}, 0);
    check("rst_in_data", bus.in_data, 0);
    check("rst_err", err_code, 0);
    check("rst_op_mode", op_mode, 0);
    check("rst_cfg_nonzero", 64'(|cfg_flat), 0);
    bus.setup_valid = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;

    // Full-config write to unit 1 and read back.
    wbuf[0] = 64'h1111_2222_3333_4444;
    wbuf[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    request(64'h2101_0000_0100_0010, 0);
    check("lit_u1w0", cfg_flat[8*DW +: DW], 64'h1111_2222_3333_4444);
    check("lit_u1w1", cfg_flat[9*DW +: DW], 64'hAAAA_BBBB_CCCC_DDDD);
    check("lit_err_ack", err_code, 8'h00);
    request(64'hA181_0000_0100_0010, 0);
    check("lit_multi_last", bus.in_data, 64'hAAAA_BBBB_CCCC_DDDD);

    // Single write then single read with backpressure.
    wbuf[0] = 64'hDEAD_BEEF_0123_4567;
    request(64'h2102_0003_0000_0008, 0);
    request(64'hA182_0003_0000_0008, 3);
    check("lit_single_rd", bus.in_data, 64'hDEAD_BEEF_0123_4567);

    // Invalid unit, then GET_ERROR.
    request(64'h2101_0000_0400_0010, 0);
    check("lit_err_unit", err_code, 8'h07);
    request(64'hA188_0000_0000_0008, 0);
    check("lit_get_error", bus.in_data, 64'h7);
    check("lit_err_kept", err_code, 8'h07);

    // Range and request violations.
    request(64'h2101_0000_0000_0048, 0);
    check("lit_err_range", err_code, 8'h06);
    request(64'h2142_0000_0000_0000, 0);
    check("lit_err_req", err_code, 8'h09);
    request(64'h4001_0000_0000_0008, 0);
    request(64'h2101_0000_0000_000C, 0);
    request(64'h2102_0008_0000_0008, 0);
    request(64'h2105_0003_0000_0008, 0);

    // Abort a 4-word write after two words; coincident word is dropped.
    wbuf[0] = 64'h0101_0101_0101_0101;
    wbuf[1] = 64'h0202_0202_0202_0202;
    wbuf[2] = 64'h0303_0303_0303_0303;
    issue_setup(64'h2101_0000_0200_0020);
    @(posedge clk); #1;
    check("abort_out_ready", bus.out_ready, 1);
    for (int i = 0; i < 2; i++) begin
      bus.out_valid = 1'b1;
      bus.out_data  = wbuf[i];
      @(posedge clk); #1;
      bus.out_valid = 1'b0;
      m_cfg[2][i] = wbuf[i];
    end
    bus.out_valid   = 1'b1;
    bus.out_data    = wbuf[2];
    bus.setup_valid = 1'b1;
    bus.setup_data  = 64'hA187_0000_0000_0008;
    @(posedge clk); #1;
    bus.out_valid   = 1'b0;
    bus.setup_valid = 1'b0;
    finish_request(64'hA187_0000_0000_0008, 0);
    check("lit_abort_w1", cfg_flat[17*DW +: DW], 64'h0202_0202_0202_0202);
    check("lit_abort_w2", cfg_flat[18*DW +: DW], 64'h0);
    check("lit_info", bus.in_data, 64'h0000_0000_0000_380F);

    // Operating mode, mode read-back, unit reset, zero-length GET.
    request(64'h2105_0003_0200_0000, 0);
    check("lit_mode_u2", op_mode[23:16], 8'h03);
    request(64'hA185_0000_0200_0008, 0);
    check("lit_mode_rd", bus.in_data, 64'h3);
    request(64'h210A_0000_0200_0000, 0);
    check("lit_mode_clr", op_mode[23:16], 8'h00);
    check("lit_u2w0_clr", cfg_flat[16*DW +: DW], 64'h0);
    request(64'hA188_0000_0000_0000, 0);

    // Reset in the middle of a data stage.
    wbuf[0] = 64'h5555_6666_7777_8888;
    issue_setup(64'h2101_0000_0300_0010);
    @(posedge clk); #1;
    bus.out_valid = 1'b1;
    bus.out_data  = wbuf[0];
    @(posedge clk); #1;
    m_cfg[3][0] = wbuf[0];
    bus.out_data = 64'h9999_9999_9999_9999;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_valid = 1'b0;
    model_reset();
    check("midrst_idle", {bus.busy, bus.status_valid, bus.out_ready}, 0);
    check("lit_midrst_u3w0", cfg_flat[24*DW +: DW], 64'h0);
    @(posedge clk); #1;
    check("midrst_no_status", bus.status_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usb_dbg_ctrl_ep.md
# usb_dbg_ctrl_ep

Parametrised control-endpoint request engine for the USB debug-class endpoint. It accepts 8-byte setup packets and decodes class SET/GET requests. It moves data-stage words between the host and a per-debug-unit configuration store, and reports per-request ACK/STALL status. It also keeps the error code returned by GET_ERROR. It sits between the endpoint packet layer (setup/data streams) and the debug units, which read configuration and operating mode directly.

## Interface
- DW, 64: data-stage word width in bits; legal values 32 or 64.
- NUM_UNITS, 4: number of debug units addressed by wIndex[15:8].
- CFG_WORDS, 8: configuration words per unit.
- CAPS, 32'h0000_380F: support-capability word returned by GET_INFO.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- setup_valid  in  1  setup packet present; always accepted, no ready.
- setup_data  in  64  [63:56] bmRequestType, [55:48] bRequest, [47:32] wValue, [31:16] wIndex, [15:0] wLength (bytes).
- out_valid / out_ready / out_data  in / out / in  1 / 1 / DW  host-to-device data-stage stream.
- in_valid / in_ready / in_data  out / in / out  1 / 1 / DW  device-to-host data-stage stream.
- status_valid  out  1  one-cycle pulse at request end.
- status_stall  out  1  qualifies status_valid: 1 = STALL, 0 = ACK.
- busy  out  1  high in any state other than IDLE.
- cfg_flat  out  NUM_UNITS*CFG_WORDS*DW  config store; unit u, word w at bits [(u*CFG_WORDS+w)*DW +: DW].
- op_mode  out  8*NUM_UNITS  per-unit operating mode.
- err_code  out  8  last request's error code.

## Operation
- States: IDLE, DECODE, OUT_DATA, IN_DATA, STATUS, STALL.
- setup_valid in any state: latch fields and go to DECODE. An in-flight transfer aborts with no status. Words already written stay written.
- DECODE checks, first failure wins:
  - bmRequestType not 0x21 (SET) or 0xA1 (GET) -> 0x09.
  - bRequest unsupported -> 0x09.
  - unit = wIndex[15:8] >= NUM_UNITS -> 0x07.
  - range violation -> 0x06.
  - Any failure -> STALL, err_code updated.
- SET requests (bmRequestType 0x21):
  - 0x01 SET_CONFIG_DATA: wLength must be a nonzero multiple of DW/8 and <= CFG_WORDS*DW/8. Words go to word 0 upward.
  - 0x02 SET_CONFIG_DATA_SINGLE: word wValue[7:0] < CFG_WORDS; wLength must equal DW/8.
  - 0x05 SET_OPERATING_MODE: op_mode[unit] <= wValue[7:0]; wLength must be 0.
  - 0x0A SET_RESET: clears all words of unit and its op_mode; wLength must be 0.
- GET requests (bmRequestType 0xA1):
  - 0x81 GET_CONFIG_DATA: same range rule as 0x01.
  - 0x82 GET_CONFIG_SINGLE: same range rule as 0x02.
  - 0x85 GET_OPERATING_MODE, 0x87 GET_INFO, 0x88 GET_ERROR: one word, value zero-extended. wLength 0 gives no data stage.
- Routing after DECODE:
  - SET with data -> OUT_DATA. Each out_valid&&out_ready writes one word. Word counter = wLength/(DW/8); STATUS after the last word.
  - GET with data -> IN_DATA.
  - Zero-length request -> STATUS; the register action is done in DECODE.
- STATUS: status_valid=1, status_stall=0 for one cycle, then IDLE. err_code <= 0x00, except GET_ERROR, which leaves err_code unchanged.
- STALL: status_valid=1, status_stall=1 for one cycle, then IDLE.
- out_ready=1 only in OUT_DATA. in_valid=1 only in IN_DATA.

## Timing
- Setup accepted on cycle 0 edge; DECODE during cycle 1.
- First data state, STATUS or STALL entered on cycle 2. STALL pulse is in cycle 2.
- OUT_DATA: one word per cycle at full rate; write visible on cfg_flat the cycle after the handshake.
- IN_DATA: in_data is registered and valid on entry. in_data/in_valid are held stable while in_ready=0. Next word is presented the cycle after each handshake.
- STATUS follows the cycle after the last data handshake.
- SET_OPERATING_MODE and SET_RESET take effect at the DECODE edge. The ACK pulse follows one cycle later.
- Reset values:
  - State: IDLE.
  - Outputs and register values: cfg_flat=0, op_mode=0, err_code=0x00, in_data=0.
  - Handshake/status: in_valid=0, out_ready=0, status_valid=0, status_stall=0, busy=0.
- rst mid-transfer returns everything to reset values on the next edge. No status is produced.
- setup_valid and rst in the same cycle: rst wins.
- setup_valid coinciding with a data handshake: the handshake word is discarded, not written.

## Test plan
- Full-config write: DW=64, setup 0x21_01_0000_0100_0010 plus words A,B -> unit1 words0/1 = A/B, ACK pulse 1 cycle after word B, err_code 0x00.
- Single read with backpressure: setup 0xA1_82_0003_0000_0008, in_ready low 3 cycles -> in_data = unit0 word3, held stable; handshake then ACK.
- Invalid unit: wIndex=0x0400 with NUM_UNITS=4 -> STALL on cycle 2, err_code 0x07. Then GET_ERROR with wLength 8 -> in_data = 0x07, err_code stays 0x07.
- Range violation: SET_CONFIG_DATA, wLength=0x48 (9 words, CFG_WORDS=8) -> STALL, err_code 0x06, no store change. Unknown bRequest 0x42 -> STALL, err_code 0x09.
- Abort: SET_CONFIG_DATA of 4 words, new setup after word 2 -> words 0-1 written, no status for the first request, second request completes normally.
- Mode/reset/info: SET_OPERATING_MODE wValue=0x03 on unit 2 -> op_mode[23:16]=0x03. SET_RESET unit 2 -> that unit's mode and words cleared. GET_INFO -> in_data = CAPS zero-extended.
